// File: rtl/axi_vip_pkg.sv
// axi_vip_pkg: shared types and constants for the AXI write-channel slave.
package axi_vip_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    typedef logic [1:0] resp_t;
    localparam resp_t OKAY   = 2'b00;
    localparam resp_t SLVERR = 2'b10;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_OK   = 2'b01;
    localparam logic [1:0] TRANS_ERR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_t;

    // A WRAP burst must be 2, 4, 8 or 16 beats long.
    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts,
// plus WRAP legality and 4 KB page-crossing flags for the burst described by
// start/size/len/burst.
module axi_burst_addr_gen
    import axi_vip_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] i_cur_addr,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_wrap_ok,
    output logic              o_cross_4k
);
    // Wide enough that the last byte of the largest INCR burst never overflows.
    localparam int EW = ADDR_W + 16;

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_total;
    logic [ADDR_W-1:0] w_bound;
    logic [ADDR_W-1:0] w_incr;
    logic [EW-1:0]     w_span;
    logic [EW-1:0]     w_last_byte;

    assign w_step      = ADDR_W'(1) << i_size;
    assign w_span      = (EW'(i_len) + EW'(1)) << i_size;
    assign w_total     = w_span[ADDR_W-1:0];
    assign w_bound     = i_start_addr & ~(w_total - ADDR_W'(1));
    assign w_incr      = (i_cur_addr & ~(w_step - ADDR_W'(1))) + w_step;
    assign w_last_byte = EW'(i_start_addr & ~(w_step - ADDR_W'(1))) + w_span - EW'(1);

    assign o_wrap_ok  = is_wrap_len(i_len) &&
                        ((i_start_addr & (w_step - ADDR_W'(1))) == {ADDR_W{1'b0}});
    assign o_cross_4k = (burst_t'(i_burst) == INCR) &&
                        (w_last_byte[EW-1:12] != (EW-12)'(i_start_addr[ADDR_W-1:12]));

    // Select the following beat address according to the burst type
    always_comb begin
        o_next_addr = i_cur_addr;
        case (burst_t'(i_burst))
            FIXED: o_next_addr = i_cur_addr;
            INCR:  o_next_addr = w_incr;
            WRAP: begin
                if (w_incr == (w_bound + w_total)) begin
                    o_next_addr = w_bound;
                end else begin
                    o_next_addr = w_incr;
                end
            end
            default: o_next_addr = i_cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_write_slave.sv
// axi_write_slave: single-outstanding AXI write slave (AW -> W beats -> B) that
// drives a word-addressed memory write port and a per-transaction status pulse.
// Build option: define AXI_WR_4KB_CHECK_EN to reject INCR bursts crossing a 4 KB page.
module axi_write_slave
    import axi_vip_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int MEM_AW = 14
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [7:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBUSRT,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        TRANS_VALID,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int         BYTE_SH  = $clog2(DATA_W / 8);
    localparam logic [2:0] MAX_SIZE = 3'(BYTE_SH);

    wr_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_start;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;
    logic              r_err;

    logic [ADDR_W-1:0] w_gen_start;
    logic [2:0]        w_gen_size;
    logic [7:0]        w_gen_len;
    logic [1:0]        w_gen_burst;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_wrap_ok;
    logic              w_cross_4k;
    logic              w_aw_illegal;
    logic              w_last_beat;
    logic              w_term_err;

    // In IDLE the generator looks at the incoming AW so legality is known at acceptance;
    // afterwards it works from the latched burst.
    assign w_gen_start = (r_state == IDLE) ? AWADDR  : r_start;
    assign w_gen_size  = (r_state == IDLE) ? AWSIZE  : r_size;
    assign w_gen_len   = (r_state == IDLE) ? AWLEN   : r_len;
    assign w_gen_burst = (r_state == IDLE) ? AWBUSRT : r_burst;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_cur_addr   (r_addr),
        .i_start_addr (w_gen_start),
        .i_size       (w_gen_size),
        .i_len        (w_gen_len),
        .i_burst      (w_gen_burst),
        .o_next_addr  (w_next_addr),
        .o_wrap_ok    (w_wrap_ok),
        .o_cross_4k   (w_cross_4k)
    );

    assign w_last_beat = (r_beat == r_len);
    // WLAST must coincide exactly with the final beat.
    assign w_term_err  = (WLAST != w_last_beat);

`ifndef AXI_WR_4KB_CHECK_EN
    // Page-cross flag is not consulted in this build.
    logic w_unused_cross_4k;
    assign w_unused_cross_4k = w_cross_4k;
`endif

    // Classify the presented AW as illegal (writes suppressed, SLVERR response)
    always_comb begin
        w_aw_illegal = (AWSIZE > MAX_SIZE) ||
                       (burst_t'(AWBUSRT) == RSVD) ||
                       ((burst_t'(AWBUSRT) == WRAP) && !w_wrap_ok);
`ifdef AXI_WR_4KB_CHECK_EN
        w_aw_illegal = w_aw_illegal || w_cross_4k;
`endif
    end

    // Burst FSM with registered handshakes, memory port and status pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            AWREADY     <= 1'b1;
            WREADY      <= 1'b0;
            BVALID      <= 1'b0;
            BRESP       <= OKAY;
            TRANS_VALID <= TRANS_IDLE;
            mem_we      <= 1'b0;
            mem_addr    <= {MEM_AW{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            r_addr      <= {ADDR_W{1'b0}};
            r_start     <= {ADDR_W{1'b0}};
            r_len       <= 8'd0;
            r_size      <= 3'd0;
            r_burst     <= 2'b00;
            r_beat      <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            TRANS_VALID <= TRANS_IDLE;
            case (r_state)
                IDLE: begin
                    if (AWVALID && AWREADY) begin
                        r_addr  <= AWADDR;
                        r_start <= AWADDR;
                        r_len   <= AWLEN;
                        r_size  <= AWSIZE;
                        r_burst <= AWBUSRT;
                        r_beat  <= 8'd0;
                        r_err   <= w_aw_illegal;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        r_state <= DATA;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                DATA: begin
                    if (WVALID && WREADY) begin
                        if (!r_err) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= MEM_AW'(r_addr >> BYTE_SH);
                            mem_wdata <= WDATA;
                        end else begin
                            mem_we <= 1'b0;
                        end
                        r_beat <= r_beat + 8'd1;
                        r_addr <= w_next_addr;
                        if (WLAST || w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            r_state <= RESP;
                            if (r_err || w_term_err) begin
                                r_err <= 1'b1;
                                BRESP <= SLVERR;
                            end else begin
                                BRESP <= OKAY;
                            end
                        end else begin
                            WREADY <= 1'b1;
                        end
                    end else begin
                        WREADY <= 1'b1;
                    end
                end
                RESP: begin
                    if (BVALID && BREADY) begin
                        BVALID      <= 1'b0;
                        TRANS_VALID <= r_err ? TRANS_ERR : TRANS_OK;
                        AWREADY     <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        BVALID <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    AWREADY <= 1'b1;
                    WREADY  <= 1'b0;
                    BVALID  <= 1'b0;
                end
            endcase
        end
    end

endmodule
